pc_sequencer: RTL and testbench

//  Next-PC controller for the fetch-stage PC register. Each cycle it selects the
//  PC source (boot vector, trap, EX branch, ID jump, or sequential PC+INST_BYTES)
//  and drives the register's next_pc / pc_hazarded inputs.
//  It holds the PC on pipeline hazards and instruction-memory back-pressure.
//  A redirect that arrives during a hold is latched and applied on release.
//  A stall watchdog flags holds that exceed the configured limit.

---
 rtl/pc_sequencer.sv | 155 +++++++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Next-PC controller that picks the fetch PC source and holds the
//            PC on hazards and back-pressure, replaying latched redirects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                INST_BYTES = 4,
    parameter int                MAX_STALL  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] curr_pc,
    input  logic              stall_i,
    input  logic              imem_ready_i,
    input  logic              trap_i,
    input  logic [ADDR_W-1:0] trap_vec_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              jmp_i,
    input  logic [ADDR_W-1:0] jmp_target_i,
    output logic [ADDR_W-1:0] next_pc,
    output logic              pc_hazarded,
    output logic              flush_if_o,
    output logic              flush_id_o,
    output logic              redirect_pend_o,
    output logic              stall_timeout_o
);

    localparam int CNT_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state, state_d;
    logic               pend_v, pend_v_d;
    logic [1:0]         pend_pri, pend_pri_d;
    logic [ADDR_W-1:0]  pend_tgt, pend_tgt_d;
    logic [CNT_W-1:0]   stall_cnt, stall_cnt_d;
    logic               timeout, timeout_d;

    logic               hold;
    logic [1:0]         new_pri;
    logic [ADDR_W-1:0]  new_tgt;
    logic               use_new;
    logic [1:0]         eff_pri;
    logic [ADDR_W-1:0]  eff_tgt;
    logic [ADDR_W-1:0]  seq_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_BOOT;
            pend_v    <= 1'b0;
            pend_pri  <= 2'd0;
            pend_tgt  <= '0;
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            pend_v    <= pend_v_d;
            pend_pri  <= pend_pri_d;
            pend_tgt  <= pend_tgt_d;
            stall_cnt <= stall_cnt_d;
            timeout   <= timeout_d;
        end
    end

    always_comb begin
        hold   = stall_i | ~imem_ready_i;
        seq_pc = curr_pc + ADDR_W'(INST_BYTES);

        new_pri = 2'd0;
        new_tgt = '0;
        if (trap_i) begin
            new_pri = 2'd3;
            new_tgt = trap_vec_i;
        end else if (br_taken_i) begin
            new_pri = 2'd2;
            new_tgt = br_target_i;
        end else if (jmp_i) begin
            new_pri = 2'd1;
            new_tgt = jmp_target_i;
        end

        // pend_pri is zero whenever nothing is pending, so one compare serves
        // both the RUN path and the HOLD release / overwrite paths.
        use_new = (new_pri != 2'd0) && (new_pri >= pend_pri);
        eff_pri = use_new ? new_pri : pend_pri;
        eff_tgt = use_new ? new_tgt : pend_tgt;
    end

    always_comb begin
        state_d     = state;
        pend_v_d    = pend_v;
        pend_pri_d  = pend_pri;
        pend_tgt_d  = pend_tgt;
        stall_cnt_d = stall_cnt;
        timeout_d   = timeout;
        next_pc     = seq_pc;
        pc_hazarded = 1'b0;
        flush_if_o  = 1'b0;
        flush_id_o  = 1'b0;

        case (state)
            S_BOOT: begin
                next_pc = RESET_PC;
                state_d = S_RUN;
            end
            S_RUN, S_HOLD: begin
                if (hold) begin
                    pc_hazarded = 1'b1;
                    next_pc     = curr_pc;
                    if (use_new) begin
                        pend_v_d   = 1'b1;
                        pend_pri_d = new_pri;
                        pend_tgt_d = new_tgt;
                    end
                    if (stall_cnt != CNT_MAX) begin
                        stall_cnt_d = stall_cnt + 1'b1;
                    end else begin
                        timeout_d = 1'b1;
                    end
                    state_d = S_HOLD;
                end else begin
                    if (eff_pri != 2'd0) begin
                        next_pc = eff_tgt;
                    end
                    flush_if_o  = (eff_pri != 2'd0);
                    flush_id_o  = (eff_pri >= 2'd2);
                    pend_v_d    = 1'b0;
                    pend_pri_d  = 2'd0;
                    stall_cnt_d = '0;
                    state_d     = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign redirect_pend_o = pend_v;
    assign stall_timeout_o = timeout;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed vector bench for pc_sequencer with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] curr_pc;
    logic        stall_i, imem_ready_i, trap_i, br_taken_i, jmp_i;
    logic [31:0] trap_vec_i, br_target_i, jmp_target_i;
    logic [31:0] next_pc;
    logic        pc_hazarded, flush_if_o, flush_id_o, redirect_pend_o, stall_timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0),
        .INST_BYTES (4),
        .MAX_STALL  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .curr_pc         (curr_pc),
        .stall_i         (stall_i),
        .imem_ready_i    (imem_ready_i),
        .trap_i          (trap_i),
        .trap_vec_i      (trap_vec_i),
        .br_taken_i      (br_taken_i),
        .br_target_i     (br_target_i),
        .jmp_i           (jmp_i),
        .jmp_target_i    (jmp_target_i),
        .next_pc         (next_pc),
        .pc_hazarded     (pc_hazarded),
        .flush_if_o      (flush_if_o),
        .flush_id_o      (flush_id_o),
        .redirect_pend_o (redirect_pend_o),
        .stall_timeout_o (stall_timeout_o)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        stall, ready, trap, br, jmp;
        logic [31:0] tv, bt, jt;
        logic        chk_pc;
        logic [31:0] exp_pc;
        logic        haz, fif, fid, pend;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input string nm, input logic [31:0] pc,
                                input logic st, input logic rd,
                                input logic tr, input logic [31:0] tv,
                                input logic br, input logic [31:0] bt,
                                input logic jm, input logic [31:0] jt,
                                input logic cp, input logic [31:0] ep,
                                input logic hz, input logic fi, input logic fd,
                                input logic pd);
        vec_t v;
        v.name = nm; v.pc = pc; v.stall = st; v.ready = rd;
        v.trap = tr; v.tv = tv; v.br = br; v.bt = bt; v.jmp = jm; v.jt = jt;
        v.chk_pc = cp; v.exp_pc = ep;
        v.haz = hz; v.fif = fi; v.fid = fd; v.pend = pd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        stall_i = 0; imem_ready_i = 1; trap_i = 0; br_taken_i = 0; jmp_i = 0;
        trap_vec_i = 0; br_target_i = 0; jmp_target_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Sequence continues from the BOOT cycle that follows reset release.
        tbl[0]  = mk("boot_ignores_jmp", 32'h1234, 0,1, 0,0, 0,0, 1,32'h80, 1,32'h0,   0,0,0,0);
        tbl[1]  = mk("seq_0",            32'h0,    0,1, 0,0, 0,0, 0,0,      1,32'h4,   0,0,0,0);
        tbl[2]  = mk("seq_4",            32'h4,    0,1, 0,0, 0,0, 0,0,      1,32'h8,   0,0,0,0);
        tbl[3]  = mk("seq_8",            32'h8,    0,1, 0,0, 0,0, 0,0,      1,32'hC,   0,0,0,0);
        tbl[4]  = mk("br_beats_jmp",     32'h100,  0,1, 0,0, 1,32'h40, 1,32'h80, 1,32'h40, 0,1,1,0);
        tbl[5]  = mk("jmp_only",         32'h40,   0,1, 0,0, 0,0, 1,32'h80, 1,32'h80,  0,1,0,0);
        tbl[6]  = mk("trap_beats_all",   32'h80,   0,1, 1,32'h200, 1,32'h40, 1,32'h90, 1,32'h200, 0,1,1,0);
        tbl[7]  = mk("seq_wrap",         32'hFFFF_FFFC, 0,1, 0,0, 0,0, 0,0, 1,32'h0, 0,0,0,0);
        tbl[8]  = mk("hold1_jmp",        32'h100,  1,1, 0,0, 0,0, 1,32'h80, 0,0,       1,0,0,0);
        tbl[9]  = mk("hold2_br",         32'h100,  1,1, 0,0, 1,32'h40, 0,0, 0,0,       1,0,0,1);
        tbl[10] = mk("hold3_jmp_lose",   32'h100,  1,1, 0,0, 0,0, 1,32'h90, 0,0,       1,0,0,1);
        tbl[11] = mk("release_br",       32'h100,  0,1, 0,0, 0,0, 0,0,      1,32'h40,  0,1,1,1);
        tbl[12] = mk("after_release",    32'h40,   0,1, 0,0, 0,0, 0,0,      1,32'h44,  0,0,0,0);
        tbl[13] = mk("hold_jmp_a",       32'h44,   1,1, 0,0, 0,0, 1,32'h80, 0,0,       1,0,0,0);
        tbl[14] = mk("release_tie_new",  32'h44,   0,1, 0,0, 0,0, 1,32'h90, 1,32'h90,  0,1,0,1);
        tbl[15] = mk("imem_wait_trap",   32'h90,   0,0, 1,32'h300, 0,0, 0,0, 0,0,      1,0,0,0);
        tbl[16] = mk("release_trap_win", 32'h90,   0,1, 0,0, 1,32'h40, 0,0, 1,32'h300, 0,1,1,1);
        tbl[17] = mk("after_trap",       32'h300,  0,1, 0,0, 0,0, 0,0,      1,32'h304, 0,0,0,0);

        rst = 1; curr_pc = 0;
        drive_idle();
        tick();
        tick();
        chk("reset next_pc", next_pc, 32'h0);
        chk("reset pc_hazarded", {31'b0, pc_hazarded}, 32'h0);
        chk("reset redirect_pend", {31'b0, redirect_pend_o}, 32'h0);
        chk("reset stall_timeout", {31'b0, stall_timeout_o}, 32'h0);
        rst = 0;

        for (int i = 0; i < 18; i++) begin
            curr_pc = tbl[i].pc; stall_i = tbl[i].stall; imem_ready_i = tbl[i].ready;
            trap_i = tbl[i].trap; trap_vec_i = tbl[i].tv;
            br_taken_i = tbl[i].br; br_target_i = tbl[i].bt;
            jmp_i = tbl[i].jmp; jmp_target_i = tbl[i].jt;
            #4;
            if (tbl[i].chk_pc) chk({tbl[i].name, " next_pc"}, next_pc, tbl[i].exp_pc);
            chk({tbl[i].name, " pc_hazarded"}, {31'b0, pc_hazarded}, {31'b0, tbl[i].haz});
            chk({tbl[i].name, " flush_if"}, {31'b0, flush_if_o}, {31'b0, tbl[i].fif});
            chk({tbl[i].name, " flush_id"}, {31'b0, flush_id_o}, {31'b0, tbl[i].fid});
            chk({tbl[i].name, " redirect_pend"}, {31'b0, redirect_pend_o}, {31'b0, tbl[i].pend});
            tick();
        end

        // Watchdog: six back-pressure cycles with a limit of four.
        drive_idle();
        curr_pc = 32'h304;
        imem_ready_i = 0;
        for (int k = 1; k <= 6; k++) begin
            #4;
            chk($sformatf("wd hold%0d pc_hazarded", k), {31'b0, pc_hazarded}, 32'h1);
            chk($sformatf("wd hold%0d stall_timeout", k), {31'b0, stall_timeout_o},
                (k == 6) ? 32'h1 : 32'h0);
            tick();
        end
        imem_ready_i = 1;
        #4;
        chk("wd release next_pc", next_pc, 32'h308);
        chk("wd release stall_timeout", {31'b0, stall_timeout_o}, 32'h1);
        tick();
        curr_pc = 32'h308;
        #4;
        chk("wd sticky stall_timeout", {31'b0, stall_timeout_o}, 32'h1);
        rst = 1;
        tick();
        chk("wd cleared by rst", {31'b0, stall_timeout_o}, 32'h0);
        rst = 0;

        // Reset while a trap is pending in HOLD.
        tick();
        curr_pc = 32'h0;
        stall_i = 1; trap_i = 1; trap_vec_i = 32'h500;
        tick();
        #4;
        chk("rsthold pend set", {31'b0, redirect_pend_o}, 32'h1);
        chk("rsthold pc_hazarded", {31'b0, pc_hazarded}, 32'h1);
        rst = 1;
        tick();
        chk("rsthold boot next_pc", next_pc, 32'h0);
        chk("rsthold pend cleared", {31'b0, redirect_pend_o}, 32'h0);
        chk("rsthold boot pc_hazarded", {31'b0, pc_hazarded}, 32'h0);
        chk("rsthold boot flush_if", {31'b0, flush_if_o}, 32'h0);
        rst = 0;
        drive_idle();
        tick();
        #4;
        chk("rsthold run next_pc", next_pc, 32'h4);
        chk("rsthold run flush_if", {31'b0, flush_if_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
